// File: rtl/sync_slicer.sv
// Horizontal sync separator: tracks the sync-tip level, slices sync with a
// qualified hysteretic threshold, measures line period and reports line lock.
module sync_slicer #(
  parameter int RESOLUTION = 8,
  parameter int OFFSET     = 16,
  parameter int HYST       = 4,
  parameter int MIN_SYNC   = 3,
  parameter int LEAK       = 64,
  parameter int LINE_MIN   = 90,
  parameter int LINE_MAX   = 110,
  parameter int LOCK_COUNT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [RESOLUTION-1:0] sample,
  input  logic                  sample_valid,
  output logic                  hsync,
  output logic                  in_sync,
  output logic                  locked,
  output logic [15:0]           line_period,
  output logic [RESOLUTION-1:0] tip_level
);

  localparam int QW = $clog2(MIN_SYNC + 1);
  localparam int LW = (LEAK > 1) ? $clog2(LEAK) : 1;
  localparam int GW = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {
    ST_ABOVE,
    ST_CAND,
    ST_SYNC
  } state_t;

  state_t                state, state_nx;
  logic [QW-1:0]         qual, qual_nx, qual_inc;
  logic [LW-1:0]         leak_cnt;
  logic [15:0]           cnt, cnt_inc;
  logic [GW-1:0]         good, good_inc;
  logic                  seen;
  logic                  fire;
  logic [RESOLUTION:0]   thr_sum, thr_hi_sum;
  logic [RESOLUTION-1:0] thr, thr_hi;
  logic                  period_ok, timeout;

  // Thresholds come from the registered tip, one bit wider so the add can
  // saturate instead of wrapping.
  assign thr_sum    = {1'b0, tip_level} + (RESOLUTION+1)'(OFFSET);
  assign thr        = thr_sum[RESOLUTION] ? '1 : thr_sum[RESOLUTION-1:0];
  assign thr_hi_sum = {1'b0, thr} + (RESOLUTION+1)'(HYST);
  assign thr_hi     = thr_hi_sum[RESOLUTION] ? '1 : thr_hi_sum[RESOLUTION-1:0];

  assign qual_inc  = qual + 1'b1;
  assign cnt_inc   = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  assign good_inc  = (good == GW'(LOCK_COUNT)) ? good : good + 1'b1;
  // The sync sample reloads cnt to 1, so cnt at the next sync equals the
  // number of valid samples between the two sync samples.
  assign period_ok = (cnt >= 16'(LINE_MIN)) && (cnt <= 16'(LINE_MAX));
  assign timeout   = (cnt >= 16'(2 * LINE_MAX));
  assign in_sync   = (state == ST_SYNC);

  // Tip tracker: follows the minimum instantly, leaks upward slowly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tip_level <= '1;
      leak_cnt  <= '0;
    end else if (sample_valid) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (sample < tip_level) begin
        tip_level <= sample;
        leak_cnt  <= '0;
      end else if (leak_cnt == LW'(LEAK - 1)) begin
        leak_cnt <= '0;
        if (tip_level != '1) tip_level <= tip_level + 1'b1;
      end else begin
        leak_cnt <= leak_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_ABOVE;
      qual  <= '0;
    end else if (sample_valid) begin
      state <= state_nx;
      qual  <= qual_nx;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_nx = state;
    qual_nx  = qual;
    fire     = 1'b0;
    case (state)
      ST_ABOVE: begin
        if (sample <= thr) begin
          qual_nx = QW'(1);
          if (MIN_SYNC == 1) begin
            state_nx = ST_SYNC;
            fire     = 1'b1;
          end else begin
            state_nx = ST_CAND;
          end
        end
      end
      ST_CAND: begin
        if (sample <= thr) begin
          qual_nx = qual_inc;
          if (qual_inc == QW'(MIN_SYNC)) begin
            state_nx = ST_SYNC;
            fire     = 1'b1;
          end
        end else begin
          state_nx = ST_ABOVE;
        end
      end
      ST_SYNC: begin
        if (sample > thr_hi) state_nx = ST_ABOVE;
      end
      default: state_nx = ST_ABOVE;
    endcase
  end

  // Period measurement and lock; a qualifying sync overrides a timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync       <= 1'b0;
      locked      <= 1'b0;
      line_period <= '0;
      cnt         <= '0;
      good        <= '0;
      seen        <= 1'b0;
    end else begin
      hsync <= 1'b0;
      if (sample_valid) begin
        hsync <= fire;
        if (fire) begin
          cnt  <= 16'd1;
          seen <= 1'b1;
          if (seen) begin
            line_period <= cnt;
            if (period_ok) begin
              good <= good_inc;
              if (good_inc == GW'(LOCK_COUNT)) locked <= 1'b1;
            end else begin
              good   <= '0;
              locked <= 1'b0;
            end
          end
        end else begin
          cnt <= cnt_inc;
          if (timeout) begin
            locked <= 1'b0;
            good   <= '0;
            seen   <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_slicer.sv
// Directed bench for sync_slicer: reset, lock-up, glitch rejection,
// hysteresis, loss of lock, tip leak and asynchronous reset.
module tb_sync_slicer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  sample;
  logic        sample_valid;
  logic        hsync, in_sync, locked;
  logic [15:0] line_period;
  logic [7:0]  tip_level;

  int n_checks  = 0;
  int n_pass    = 0;
  int n_fail    = 0;
  int hsync_cnt = 0;
  int h0;

  sync_slicer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample       (sample),
    .sample_valid (sample_valid),
    .hsync        (hsync),
    .in_sync      (in_sync),
    .locked       (locked),
    .line_period  (line_period),
    .tip_level    (tip_level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (hsync === 1'b1) hsync_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clk_in(input logic [7:0] s, input logic v);
    @(negedge clk);
    sample       = s;
    sample_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] s, input int gap);
    clk_in(s, 1'b1);
    for (int i = 1; i < gap; i++) clk_in(s, 1'b0);
  endtask

  task automatic sync_run(input logic [7:0] lvl, input int n, input int gap);
    for (int i = 0; i < n; i++) send(lvl, gap);
  endtask

  task automatic level_run(input int n, input int gap);
    for (int i = 0; i < n; i++) send(8'd200, gap);
  endtask

  task automatic async_reset_check(input string tag);
    sample_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check({tag, "_hsync"},   32'(hsync), 0);
    check({tag, "_in_sync"}, 32'(in_sync), 0);
    check({tag, "_locked"},  32'(locked), 0);
    check({tag, "_period"},  32'(line_period), 0);
    check({tag, "_tip"},     32'(tip_level), 255);
    @(negedge clk) reset_n = 1'b1;
  endtask

  initial begin
    reset_n      = 1'b0;
    sample       = 8'd0;
    sample_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hsync",   32'(hsync), 0);
    check("rst_in_sync", 32'(in_sync), 0);
    check("rst_locked",  32'(locked), 0);
    check("rst_period",  32'(line_period), 0);
    check("rst_tip",     32'(tip_level), 255);
    @(negedge clk) reset_n = 1'b1;

    // Line 1, valid every 4th clock: hsync after the 3rd sync sample.
    send(8'd40, 4);
    send(8'd40, 4);
    check("pre_qual_hsync_cnt", hsync_cnt, 0);
    clk_in(8'd40, 1'b1);
    check("first_hsync",   32'(hsync), 1);
    check("first_in_sync", 32'(in_sync), 1);
    check("first_tip",     32'(tip_level), 40);
    check("first_period",  32'(line_period), 0);
    clk_in(8'd40, 1'b0);
    check("hsync_one_wide", 32'(hsync), 0);
    repeat (2) clk_in(8'd40, 1'b0);
    send(8'd40, 4);
    send(8'd40, 4);
    send(8'd200, 4);
    check("leave_sync", 32'(in_sync), 0);
    level_run(94, 4);

    // Line 2: first measured period.
    sync_run(8'd40, 5, 4);
    check("l2_period", 32'(line_period), 100);
    check("l2_locked", 32'(locked), 0);
    check("l2_tip",    32'(tip_level), 40);
    level_run(95, 4);
    for (int k = 3; k <= 4; k++) begin
      sync_run(8'd40, 5, 4);
      level_run(95, 4);
    end
    check("l4_locked", 32'(locked), 0);

    // Line 5: fourth in-range period gives lock.
    sync_run(8'd40, 5, 4);
    check("l5_locked",    32'(locked), 1);
    check("l5_hsync_cnt", hsync_cnt, 5);
    level_run(95, 4);

    // Line 6: two-sample dip mid-line must be rejected.
    sync_run(8'd40, 5, 4);
    level_run(40, 4);
    h0 = hsync_cnt;
    sync_run(8'd40, 2, 4);
    check("glitch_cand_in_sync", 32'(in_sync), 0);
    level_run(1, 4);
    check("glitch_above_in_sync", 32'(in_sync), 0);
    level_run(52, 4);
    check("glitch_no_hsync", hsync_cnt, h0);
    check("glitch_period",   32'(line_period), 100);

    // Line 7: period still measured sync-to-sync across the dip.
    sync_run(8'd40, 5, 4);
    check("l7_period", 32'(line_period), 100);
    check("l7_locked", 32'(locked), 1);
    level_run(95, 4);

    // Line 8: hysteresis between thr=56 and thr_hi=60.
    h0 = hsync_cnt;
    sync_run(8'd40, 3, 4);
    check("hyst_hsync_cnt", hsync_cnt, h0 + 1);
    check("hyst_in_sync",   32'(in_sync), 1);
    for (int i = 0; i < 6; i++) begin
      send((i % 2) ? 8'd59 : 8'd57, 4);
      check("hyst_hold_in_sync", 32'(in_sync), 1);
    end
    send(8'd61, 4);
    check("hyst_exit_in_sync", 32'(in_sync), 0);
    check("hyst_single_hsync", hsync_cnt, h0 + 1);

    // No more syncs: lock drops on the 220th valid sample after the last one.
    level_run(212, 4);
    check("timeout_219_locked", 32'(locked), 1);
    level_run(1, 4);
    check("timeout_220_locked", 32'(locked), 0);
    check("timeout_period",     32'(line_period), 100);

    // Valid every clock: re-lock, then a 150-sample period drops lock.
    for (int k = 0; k < 5; k++) begin
      sync_run(8'd40, 5, 1);
      level_run(95, 1);
    end
    check("relock_locked", 32'(locked), 1);
    check("relock_period", 32'(line_period), 100);
    sync_run(8'd40, 5, 1);
    level_run(145, 1);
    sync_run(8'd40, 5, 1);
    check("long_period",  32'(line_period), 150);
    check("long_locked",  32'(locked), 0);
    check("long_in_sync", 32'(in_sync), 1);

    // Asynchronous reset while in SYNC.
    async_reset_check("rst_mid_sync");

    // Tip leak: sync at 60, tip starts at 40 and leaks up 1 LSB per 64 samples.
    h0 = hsync_cnt;
    clk_in(8'd40, 1'b1);
    for (int n = 1; n <= 1404; n++) begin
      clk_in(((n % 100) < 5) ? 8'd60 : 8'd200, 1'b1);
      if (n == 64)   check("leak_tip_64",   32'(tip_level), 41);
      if (n == 299)  check("leak_no_early_hsync", hsync_cnt, h0);
      if (n == 302)  check("leak_first_hsync", 32'(hsync), 1);
      if (n == 303)  check("leak_b2b_one_wide", 32'(hsync), 0);
      if (n == 640)  check("leak_tip_640",  32'(tip_level), 50);
      if (n == 1280) check("leak_tip_1280", 32'(tip_level), 60);
      if (n == 1344) check("leak_tip_1344", 32'(tip_level), 61);
      if (n == 1400) check("leak_tip_sat",  32'(tip_level), 60);
    end
    check("leak_hsync_cnt", hsync_cnt, h0 + 12);
    check("leak_period",    32'(line_period), 100);
    check("leak_locked",    32'(locked), 1);
    check("leak_in_sync",   32'(in_sync), 1);

    // Reset while locked and in SYNC, then a fresh qualified sync.
    async_reset_check("rst_locked");
    clk_in(8'd40, 1'b1);
    check("fresh_hsync_1", 32'(hsync), 0);
    clk_in(8'd40, 1'b1);
    check("fresh_hsync_2", 32'(hsync), 0);
    clk_in(8'd40, 1'b1);
    check("fresh_hsync_3",  32'(hsync), 1);
    check("fresh_period",   32'(line_period), 0);
    clk_in(8'd40, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
